// File: rtl/fp_mp_mul_array_pipe.sv
// fp_mp_mul_array_pipe: two-stage elastic lane-wise FP16/FP32/FP64/BF16 multiplier; FP_MP_MUL_FLAGS_EN adds sticky exception flags
module fp_mp_mul_array_pipe #(
    parameter int DATA_W = 160
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_mode,
    output logic [DATA_W-1:0] out_p
`ifdef FP_MP_MUL_FLAGS_EN
   ,input  logic              flags_clr,
    output logic [3:0]        flags
`endif
);
    localparam int N16 = DATA_W / 16;
    localparam int N32 = DATA_W / 32;
    localparam int N64 = DATA_W / 64;

    // per-lane S1 result; sp: 0 finite, 1 zero, 2 inf, 3 quiet NaN
    typedef struct packed {
        logic [1:0]   sp;
        logic         sign;
        logic         inv;
        logic [12:0]  exp;
        logic [105:0] prod;
    } rec_t;

    function automatic logic [6:0] fw_of(input logic [1:0] m);
        return m == 2'd0 ? 7'd10 : m == 2'd1 ? 7'd23 : m == 2'd2 ? 7'd52 : 7'd7;
    endfunction

    function automatic logic [6:0] ew_of(input logic [1:0] m);
        return m == 2'd0 ? 7'd5 : m == 2'd2 ? 7'd11 : 7'd8;
    endfunction

    function automatic logic [6:0] w_of(input logic [1:0] m);
        return m == 2'd1 ? 7'd32 : m == 2'd2 ? 7'd64 : 7'd16;
    endfunction

    function automatic int n_of(input logic [1:0] m);
        return m == 2'd1 ? N32 : m == 2'd2 ? N64 : N16;
    endfunction

    function automatic rec_t s1f(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b);
        logic [6:0]  fw, ew, w;
        logic [12:0] emax, ea, eb;
        logic [63:0] fmask, fa, fb, qbit;
        logic        an, bn, ai, bi, az, bz, sa, sb;
        rec_t        r;
        fw     = fw_of(m);
        ew     = ew_of(m);
        w      = w_of(m);
        emax   = (13'd1 << ew) - 13'd1;
        fmask  = (64'd1 << fw) - 64'd1;
        qbit   = 64'd1 << (fw - 7'd1);
        ea     = 13'((a >> fw) & 64'(emax));
        eb     = 13'((b >> fw) & 64'(emax));
        fa     = a & fmask;
        fb     = b & fmask;
        an     = ea == emax && fa != 64'd0;
        bn     = eb == emax && fb != 64'd0;
        ai     = ea == emax && fa == 64'd0;
        bi     = eb == emax && fb == 64'd0;
        az     = ea == 13'd0;
        bz     = eb == 13'd0;
        sa     = an && (fa & qbit) == 64'd0;
        sb     = bn && (fb & qbit) == 64'd0;
        r.sp   = (an || bn || (ai && bz) || (az && bi)) ? 2'd3 : (ai || bi) ? 2'd2 : (az || bz) ? 2'd1 : 2'd0;
        r.sign = 1'((a ^ b) >> (w - 7'd1));
        r.inv  = sa || sb || (ai && bz) || (az && bi);
        r.exp  = ea + eb - ((13'd1 << (ew - 7'd1)) - 13'd1);
        r.prod = 106'(fa | (64'd1 << fw)) * 106'(fb | (64'd1 << fw));
        return r;
    endfunction

    // returns {invalid, overflow, underflow, inexact, packed lane value}
    function automatic logic [67:0] s2f(input logic [1:0] m, input rec_t r);
        logic [6:0]  fw, w, sh;
        logic [12:0] emax, e;
        logic [63:0] sgn, inf_v, frac;
        logic        hi, lost;
        fw    = fw_of(m);
        w     = w_of(m);
        emax  = (13'd1 << ew_of(m)) - 13'd1;
        hi    = r.prod >= (106'd1 << {fw, 1'b1});
        sh    = hi ? fw + 7'd1 : fw;
        e     = r.exp + 13'(hi);
        frac  = 64'(r.prod >> sh) & ((64'd1 << fw) - 64'd1);
        lost  = (r.prod & ((106'd1 << sh) - 106'd1)) != 106'd0;
        sgn   = 64'(r.sign) << (w - 7'd1);
        inf_v = sgn | (64'(emax) << fw);
        return r.sp == 2'd3 ? {r.inv, 3'b000, (64'(emax) << fw) | (64'd1 << (fw - 7'd1))}
             : r.sp == 2'd2 ? {4'b0000, inf_v}
             : r.sp == 2'd1 ? {4'b0000, sgn}
             : $signed(e) < 13'sd1 ? {4'b0011, sgn}
             : $signed(e) >= $signed(emax) ? {4'b0101, inf_v}
             : {3'b000, lost, sgn | (64'(e) << fw) | frac};
    endfunction

    logic              s1_v_q, s1_v_d, out_v_q, out_v_d, s1_ld, s2_ld;
    logic [1:0]        s1_mode_q, s1_mode_d, out_mode_q, out_mode_d;
    logic [DATA_W-1:0] out_p_q, out_p_d, p_acc;
    logic [63:0]       lmask, sh_a, sh_b;
    logic [67:0]       lane_r;
    logic [3:0]        beat_f;
    rec_t              s1_rec_q [N16];
    rec_t              s1_rec_d [N16];

    // handshake: each stage loads when empty or when its content moves on this edge
    always_comb begin
        in_ready   = !s1_v_q || !out_v_q || out_ready;
        s1_ld      = in_valid && in_ready;
        s2_ld      = s1_v_q && (!out_v_q || out_ready);
        s1_v_d     = s1_ld || (s1_v_q && !s2_ld);
        s1_mode_d  = s1_ld ? in_mode : s1_mode_q;
        out_v_d    = s2_ld || (out_v_q && !out_ready);
        out_mode_d = s2_ld ? s1_mode_q : out_mode_q;
        out_p_d    = s2_ld ? p_acc : out_p_q;
    end

    // S1: slice lanes for the incoming mode, detect specials, add exponents, multiply mantissas
    always_comb begin
        lmask = (64'd1 << w_of(in_mode)) - 64'd1;
        sh_a  = '0;
        sh_b  = '0;
        for (int i = 0; i < N16; i++) begin
            sh_a        = 64'(in_a >> (i * int'(w_of(in_mode))));
            sh_b        = 64'(in_b >> (i * int'(w_of(in_mode))));
            s1_rec_d[i] = s1_ld ? s1f(in_mode, sh_a & lmask, sh_b & lmask) : s1_rec_q[i];
        end
    end

    // S2: normalise and truncate each live lane, repack; lanes beyond the mode's count stay 0
    always_comb begin
        p_acc  = '0;
        beat_f = '0;
        lane_r = '0;
        for (int i = 0; i < N16; i++) begin
            lane_r = s2f(s1_mode_q, s1_rec_q[i]);
            if (i < n_of(s1_mode_q)) begin
                p_acc  = p_acc | (DATA_W'(lane_r[63:0]) << (i * int'(w_of(s1_mode_q))));
                beat_f = beat_f | lane_r[67:64];
            end
        end
    end

    // stage valids, modes and result; reset drops any in-flight beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_mode_q  <= '0;
            out_v_q    <= 1'b0;
            out_mode_q <= '0;
            out_p_q    <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_mode_q  <= s1_mode_d;
            out_v_q    <= out_v_d;
            out_mode_q <= out_mode_d;
            out_p_q    <= out_p_d;
        end
    end

    // lane records are only consumed while s1_v_q is set, so they carry no reset
    always_ff @(posedge clk) begin
        s1_rec_q <= s1_rec_d;
    end

    assign out_valid = out_v_q;
    assign out_mode  = out_mode_q;
    assign out_p     = out_p_q;

`ifdef FP_MP_MUL_FLAGS_EN
    logic [3:0] out_f_q, out_f_d, flags_q, flags_d;

    // flags of the beat held in S2, folded into the sticky set on each output transfer
    always_comb begin
        out_f_d = s2_ld ? beat_f : out_f_q;
        flags_d = flags_clr ? 4'd0 : flags_q | ((out_v_q && out_ready) ? out_f_q : 4'd0);
    end

    // flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_f_q <= '0;
            flags_q <= '0;
        end else begin
            out_f_q <= out_f_d;
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    logic unused_flags;
    assign unused_flags = ^beat_f;
`endif
endmodule
